fractran_prog_seq: RTL and testbench

- Program store and sequencer that sits directly upstream of the Fractran execution core.
- Accepts a byte-serial load of up to DEPTH fractions, each a numerator then a denominator.
- Presents the current fraction to the core and steps through the list on the core's hit/miss verdicts.
- A hit restarts from entry 0. A miss on the last entry halts the program.

---
 rtl/fractran_prog_seq_if.sv | 53 +++++
 rtl/fractran_prog_seq.sv | 133 +++++++++++++
 tb/tb_fractran_prog_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fractran_prog_seq_if.sv
// +----------------------------------------------------------------------------+
// | fractran_prog_seq_if                                                       |
// | Load, control and fraction-presentation bus of the Fractran program store. |
// | Optional: FRACTRAN_STEP_CNT_EN adds the 16-bit steps counter output.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fractran_prog_seq_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             clr;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic             run;
  logic             hit;
  logic             miss;
  logic             frac_valid;
  logic [WIDTH-1:0] frac_num;
  logic [WIDTH-1:0] frac_den;
  logic [AW-1:0]    frac_idx;
  logic [AW:0]      count;
  logic             halted;
  logic             err;
`ifdef FRACTRAN_STEP_CNT_EN
  logic [15:0]      steps;

  modport slave (
    input  clr, ld_valid, ld_data, ld_last, run, hit, miss,
    output ld_ready, frac_valid, frac_num, frac_den, frac_idx, count, halted, err, steps
  );
  modport master (
    output clr, ld_valid, ld_data, ld_last, run, hit, miss,
    input  ld_ready, frac_valid, frac_num, frac_den, frac_idx, count, halted, err, steps
  );
`else
  modport slave (
    input  clr, ld_valid, ld_data, ld_last, run, hit, miss,
    output ld_ready, frac_valid, frac_num, frac_den, frac_idx, count, halted, err
  );
  modport master (
    output clr, ld_valid, ld_data, ld_last, run, hit, miss,
    input  ld_ready, frac_valid, frac_num, frac_den, frac_idx, count, halted, err
  );
`endif
endinterface

`default_nettype wire

// File: rtl/fractran_prog_seq.sv
// +----------------------------------------------------------------------------+
// | fractran_prog_seq                                                          |
// | Byte-serial program store and hit/miss sequencer for a Fractran core.      |
// | Optional: FRACTRAN_STEP_CNT_EN counts accepted hits on bus.steps.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fractran_prog_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  fractran_prog_seq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state;
  logic             den_phase;
  logic [WIDTH-1:0] num_mem [DEPTH];
  logic [WIDTH-1:0] den_mem [DEPTH];

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] nxt_idx;
  logic          ld_fire;
  logic          last_entry;

  assign wr_idx     = bus.count[AW-1:0];
  assign nxt_idx    = bus.frac_idx + 1'b1;
  assign ld_fire    = bus.ld_valid && bus.ld_ready && (state == S_LOAD) && !bus.clr;
  assign last_entry = ({1'b0, bus.frac_idx} == (bus.count - {{AW{1'b0}}, 1'b1}));

  // Program contents carry no reset; entries are only read after being loaded.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      if (!den_phase) num_mem[wr_idx] <= bus.ld_data;
      else            den_mem[wr_idx] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_LOAD;
      den_phase      <= 1'b0;
      bus.count      <= '0;
      bus.ld_ready   <= 1'b1;
      bus.frac_valid <= 1'b0;
      bus.frac_idx   <= '0;
      bus.frac_num   <= '0;
      bus.frac_den   <= '0;
      bus.halted     <= 1'b0;
      bus.err        <= 1'b0;
`ifdef FRACTRAN_STEP_CNT_EN
      bus.steps      <= '0;
`endif
    end else if (bus.clr) begin
      state          <= S_LOAD;
      den_phase      <= 1'b0;
      bus.count      <= '0;
      bus.ld_ready   <= 1'b1;
      bus.frac_valid <= 1'b0;
      bus.frac_idx   <= '0;
      bus.frac_num   <= '0;
      bus.frac_den   <= '0;
      bus.halted     <= 1'b0;
      bus.err        <= 1'b0;
`ifdef FRACTRAN_STEP_CNT_EN
      bus.steps      <= '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (ld_fire) begin
            den_phase <= !den_phase;
            if (den_phase) begin
              bus.count <= bus.count + 1'b1;
              if (bus.ld_data == '0) bus.err <= 1'b1;
              // A full store ends the load even without ld_last.
              if (bus.ld_last || (&wr_idx)) begin
                state        <= S_READY;
                bus.ld_ready <= 1'b0;
              end
            end
          end
        end
        S_READY, S_HALT: begin
          if (bus.run) begin
            state          <= S_RUN;
            bus.frac_valid <= 1'b1;
            bus.frac_idx   <= '0;
            bus.frac_num   <= num_mem[0];
            bus.frac_den   <= den_mem[0];
            bus.halted     <= 1'b0;
`ifdef FRACTRAN_STEP_CNT_EN
            bus.steps      <= '0;
`endif
          end
        end
        S_RUN: begin
          if (bus.hit) begin
            bus.frac_idx <= '0;
            bus.frac_num <= num_mem[0];
            bus.frac_den <= den_mem[0];
`ifdef FRACTRAN_STEP_CNT_EN
            if (bus.steps != 16'hFFFF) bus.steps <= bus.steps + 16'd1;
`endif
          end else if (bus.miss) begin
            if (last_entry) begin
              state          <= S_HALT;
              bus.frac_valid <= 1'b0;
              bus.halted     <= 1'b1;
            end else begin
              bus.frac_idx <= nxt_idx;
              bus.frac_num <= num_mem[nxt_idx];
              bus.frac_den <= den_mem[nxt_idx];
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fractran_prog_seq.sv
// +----------------------------------------------------------------------------+
// | tb_fractran_prog_seq                                                       |
// | Randomized bench for fractran_prog_seq against a queue-based program model.|
// | Optional: FRACTRAN_STEP_CNT_EN enables the steps counter checks.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fractran_prog_seq;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fractran_prog_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  fractran_prog_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Model: the program is a list of fractions; execution is "which entry is shown".
  logic [WIDTH-1:0] p_num[$];
  logic [WIDTH-1:0] p_den[$];
  logic [WIDTH-1:0] pend_num;
  bit               have_num;
  int               mode;      // 0 load, 1 ready, 2 run, 3 halt
  int               pos;
  bit               m_valid, m_halted, m_err;
  logic [WIDTH-1:0] m_num, m_den;
  int               m_steps;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    p_num.delete(); p_den.delete();
    have_num = 0; mode = 0; pos = 0;
    m_valid = 0; m_halted = 0; m_err = 0; m_num = '0; m_den = '0; m_steps = 0;
  endtask

  task automatic show(input int i);
    pos = i; m_num = p_num[i]; m_den = p_den[i];
  endtask

  task automatic model_step();
    if (bus.clr) begin
      model_clear();
    end else if (mode == 0) begin
      if (bus.ld_valid) begin
        if (!have_num) begin
          pend_num = bus.ld_data; have_num = 1;
        end else begin
          p_num.push_back(pend_num); p_den.push_back(bus.ld_data); have_num = 0;
          if (bus.ld_data == 0) m_err = 1;
          if (bus.ld_last || p_num.size() == DEPTH) mode = 1;
        end
      end
    end else if (mode == 1 || mode == 3) begin
      if (bus.run) begin
        mode = 2; show(0); m_valid = 1; m_halted = 0; m_steps = 0;
      end
    end else begin
      if (bus.hit) begin
        show(0);
        if (m_steps < 65535) m_steps++;
      end else if (bus.miss) begin
        if (pos + 1 < p_num.size()) show(pos + 1);
        else begin mode = 3; m_valid = 0; m_halted = 1; end
      end
    end
  endtask

  task automatic check_all();
    chk("ld_ready",   32'(bus.ld_ready),   32'(mode == 0));
    chk("frac_valid", 32'(bus.frac_valid), 32'(m_valid));
    chk("frac_idx",   32'(bus.frac_idx),   32'(pos));
    chk("frac_num",   32'(bus.frac_num),   32'(m_num));
    chk("frac_den",   32'(bus.frac_den),   32'(m_den));
    chk("count",      32'(bus.count),      32'(p_num.size()));
    chk("halted",     32'(bus.halted),     32'(m_halted));
    chk("err",        32'(bus.err),        32'(m_err));
`ifdef FRACTRAN_STEP_CNT_EN
    chk("steps",      32'(bus.steps),      32'(m_steps));
`endif
  endtask

  task automatic cyc(input bit c, input bit lv, input logic [WIDTH-1:0] d,
                     input bit ll, input bit r, input bit h, input bit m);
    @(negedge clk);
    bus.clr = c; bus.ld_valid = lv; bus.ld_data = d; bus.ld_last = ll;
    bus.run = r; bus.hit = h; bus.miss = m;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic idle(); cyc(0, 0, '0, 0, 0, 0, 0); endtask
  task automatic byte_in(input logic [WIDTH-1:0] d, input bit ll); cyc(0, 1, d, ll, 0, 0, 0); endtask
  task automatic do_run();  cyc(0, 0, '0, 0, 1, 0, 0); endtask
  task automatic do_hit();  cyc(0, 0, '0, 0, 0, 1, 0); endtask
  task automatic do_miss(); cyc(0, 0, '0, 0, 0, 0, 1); endtask
  task automatic do_clr();  cyc(1, 0, '0, 0, 0, 0, 0); endtask

  task automatic async_reset();
    @(negedge clk);
    bus.clr = 0; bus.ld_valid = 0; bus.run = 0; bus.hit = 0; bus.miss = 0; bus.ld_last = 0;
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_load(input int n);
    for (int i = 0; i < n; i++) begin
      logic [WIDTH-1:0] dn;
      dn = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0) idle();
      byte_in(WIDTH'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle();
      byte_in(dn, (i == n - 1) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.clr = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
    bus.run = 0; bus.hit = 0; bus.miss = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Two-fraction program {3/2, 5/7}
    byte_in(8'd3, 1); byte_in(8'd2, 0); byte_in(8'd5, 0); byte_in(8'd7, 1);
    idle(); do_run();
    do_miss(); do_hit(); do_miss(); do_miss();
    do_hit(); do_miss(); do_run();
    cyc(0, 0, '0, 0, 0, 0, 0);
    do_miss(); cyc(0, 0, '0, 0, 1, 1, 1);

    // Full store without ld_last, extra byte, then walk to halt
    do_clr();
    for (int i = 0; i < DEPTH; i++) begin
      byte_in(WIDTH'(10 + i), 0); byte_in(WIDTH'(20 + i), 0);
    end
    byte_in(8'hAA, 1);
    do_run();
    for (int i = 0; i < DEPTH; i++) do_miss();
    do_miss(); do_hit();

    // Zero denominator is sticky through run/halt until clr
    do_clr();
    byte_in(8'd1, 0); byte_in(8'd0, 0); byte_in(8'd4, 0); byte_in(8'd9, 1);
    do_run(); do_miss(); do_miss(); do_run(); do_miss(); do_miss();
    do_clr(); idle();

    // Reset mid-load after three bytes, then a clean reload
    byte_in(8'd6, 0); byte_in(8'd5, 0); byte_in(8'd4, 0);
    async_reset();
    byte_in(8'd8, 0); byte_in(8'd3, 1);
    do_run(); do_miss(); do_run();

    // Randomized programs and execution traffic
    for (int it = 0; it < 40; it++) begin
      do_clr();
      rand_load($urandom_range(1, DEPTH));
      for (int k = 0; k < 60; k++)
        cyc(($urandom_range(0, 63) == 0), 1'($urandom), WIDTH'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) async_reset();
    end

`ifdef FRACTRAN_STEP_CNT_EN
    do_clr();
    byte_in(8'd3, 0); byte_in(8'd2, 1);
    do_run();
    repeat (5) do_hit();
    do_miss(); do_run();
    repeat (65540) cyc(0, 0, '0, 0, 0, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
